// File: rtl/branch_pkg.sv
// Shared encodings for the execute-stage branch resolution unit.
package branch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  typedef enum logic {
    IDLE   = 1'b0,
    SHADOW = 1'b1
  } state_t;

  // Two-bit saturating counter step toward the resolved direction.
  function automatic ctr_t sat_update(input ctr_t c, input logic taken);
    ctr_t n;
    n = c;
    case (c)
      SNT: n = taken ? WNT : SNT;
      WNT: n = taken ? WT  : SNT;
      WT:  n = taken ? ST  : WNT;
      ST:  n = taken ? ST  : WT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Pipeline/comparator signal bundle around the branch resolution unit.
interface branch_resolve_if;
  import branch_pkg::*;

  logic            io_ex_valid;
  logic [2:0]      io_ex_funct3;
  logic [XLEN-1:0] io_ex_pc;
  logic [XLEN-1:0] io_ex_target;
  logic            io_ex_predTaken;
  logic            io_stall;
  logic            io_BrEq;
  logic            io_BrLt;
  logic            io_BrUn;
  logic [XLEN-1:0] io_if_pc;
  logic            io_if_predTaken;
  logic            io_redirect;
  logic [XLEN-1:0] io_redirect_pc;
  logic            io_flush;
  logic [XLEN-1:0] io_branches;
  logic [XLEN-1:0] io_mispredicts;

  modport master (
    output io_ex_valid, io_ex_funct3, io_ex_pc, io_ex_target, io_ex_predTaken,
           io_stall, io_BrEq, io_BrLt, io_if_pc,
    input  io_BrUn, io_if_predTaken, io_redirect, io_redirect_pc, io_flush,
           io_branches, io_mispredicts
  );

  modport slave (
    input  io_ex_valid, io_ex_funct3, io_ex_pc, io_ex_target, io_ex_predTaken,
           io_stall, io_BrEq, io_BrLt, io_if_pc,
    output io_BrUn, io_if_predTaken, io_redirect, io_redirect_pc, io_flush,
           io_branches, io_mispredicts
  );

endinterface

// File: rtl/branch_bht.sv
// Branch history table: 2-bit saturating counters, one async read port and
// one synchronous write port.
module branch_bht
  import branch_pkg::*;
#(
  parameter int unsigned IDX_BITS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_pred_c,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_taken
);

  localparam int unsigned DEPTH = 1 << IDX_BITS;

  ctr_t table_q [DEPTH];

  // Reset trains every entry to weakly not-taken.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        table_q[IDX_BITS'(i)] <= WNT;
      end
    end else if (wr_en) begin
      table_q[wr_idx] <= sat_update(table_q[wr_idx], wr_taken);
    end
  end

  // Same-cycle read of a written entry sees the pre-update value.
  assign rd_pred_c = table_q[rd_idx][1];

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: direction decode, mispredict redirect,
// BHT training and branch/mispredict counters.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int unsigned BHT_IDX_BITS = 4
) (
  input logic             clock,
  input logic             reset,
  branch_resolve_if.slave bus
);

  localparam int unsigned IDX_LO = 2;
  localparam int unsigned IDX_HI = BHT_IDX_BITS + IDX_LO - 1;

  state_t          state_q;
  logic            redirect_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic [XLEN-1:0] branches_q;
  logic [XLEN-1:0] mispredicts_q;

  logic            legal_c;
  logic            taken_c;
  logic            resolve_c;
  logic            mispredict_c;
  logic            unused_if_pc_bits;

  // Direction from comparator flags; reserved encodings never resolve.
  always_comb begin
    taken_c = 1'b0;
    legal_c = 1'b1;
    case (bus.io_ex_funct3)
      F3_BEQ:           taken_c = bus.io_BrEq;
      F3_BNE:           taken_c = ~bus.io_BrEq;
      F3_BLT, F3_BLTU:  taken_c = bus.io_BrLt;
      F3_BGE, F3_BGEU:  taken_c = ~bus.io_BrLt;
      default:          legal_c = 1'b0;
    endcase
  end

  assign resolve_c    = bus.io_ex_valid & ~bus.io_stall & legal_c & (state_q == IDLE);
  assign mispredict_c = resolve_c & (taken_c != bus.io_ex_predTaken);

  // FSM, redirect registers and counters; SHADOW squashes the wrong-path EX slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else begin
      redirect_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (resolve_c) begin
            branches_q <= branches_q + XLEN'(1);
          end
          if (mispredict_c) begin
            mispredicts_q <= mispredicts_q + XLEN'(1);
            state_q       <= SHADOW;
            redirect_q    <= 1'b1;
            redirect_pc_q <= taken_c ? bus.io_ex_target : bus.io_ex_pc + XLEN'(4);
          end
        end
        SHADOW:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  branch_bht #(
    .IDX_BITS (BHT_IDX_BITS)
  ) u_bht (
    .clock     (clock),
    .reset     (reset),
    .rd_idx    (bus.io_if_pc[IDX_HI:IDX_LO]),
    .rd_pred_c (bus.io_if_predTaken),
    .wr_en     (resolve_c),
    .wr_idx    (bus.io_ex_pc[IDX_HI:IDX_LO]),
    .wr_taken  (taken_c)
  );

  assign unused_if_pc_bits = ^{bus.io_if_pc[XLEN-1:IDX_HI+1], bus.io_if_pc[IDX_LO-1:0]};

  assign bus.io_BrUn        = bus.io_ex_funct3[1];
  assign bus.io_redirect    = redirect_q;
  assign bus.io_flush       = redirect_q;
  assign bus.io_redirect_pc = redirect_pc_q;
  assign bus.io_branches    = branches_q;
  assign bus.io_mispredicts = mispredicts_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus random
// traffic against a behavioural model of the resolution rules.
module tb_branch_resolve;

  logic clock;
  logic reset;
  branch_resolve_if bus ();

  branch_resolve #(.BHT_IDX_BITS(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  // Model state
  int          m_bht [16];
  bit          m_red;
  bit [31:0]   m_rpc;
  bit [31:0]   m_br;
  bit [31:0]   m_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_legal(input bit [2:0] f3);
    return f3 inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  endfunction

  function automatic bit m_taken(input bit [2:0] f3, input bit eq, input bit lt);
    case (f3)
      3'd0:       return eq;
      3'd1:       return !eq;
      3'd4, 3'd6: return lt;
      3'd5, 3'd7: return !lt;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic int m_idx(input bit [31:0] pc);
    return int'((pc >> 2) & 32'hF);
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit tk;
    int i;
    if (reset) begin
      m_red = 0; m_rpc = 0; m_br = 0; m_mis = 0;
      for (int k = 0; k < 16; k++) m_bht[k] = 1;
    end else if (m_red) begin
      m_red = 0;
    end else if (bus.io_ex_valid && !bus.io_stall && m_legal(bus.io_ex_funct3)) begin
      tk = m_taken(bus.io_ex_funct3, bus.io_BrEq, bus.io_BrLt);
      i  = m_idx(bus.io_ex_pc);
      m_br = m_br + 1;
      m_bht[i] = tk ? ((m_bht[i] < 3) ? m_bht[i] + 1 : 3) : ((m_bht[i] > 0) ? m_bht[i] - 1 : 0);
      if (tk != bus.io_ex_predTaken) begin
        m_mis = m_mis + 1;
        m_red = 1;
        m_rpc = tk ? bus.io_ex_target : bus.io_ex_pc + 32'd4;
      end
    end
  endtask

  task automatic compare();
    chk("brun", 32'(bus.io_BrUn), 32'(bus.io_ex_funct3[1]));
    chk("if_pred", 32'(bus.io_if_predTaken), 32'(m_bht[m_idx(bus.io_if_pc)] >= 2));
    chk("redirect", 32'(bus.io_redirect), 32'(m_red));
    chk("flush", 32'(bus.io_flush), 32'(m_red));
    if (m_red) chk("redirect_pc", bus.io_redirect_pc, m_rpc);
    chk("branches", bus.io_branches, m_br);
    chk("mispredicts", bus.io_mispredicts, m_mis);
  endtask

  task automatic tick();
    #1;
    if (checking) compare();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit v, input bit [2:0] f3, input bit [31:0] pc, input bit [31:0] tgt,
                       input bit pred, input bit stall, input bit eq, input bit lt);
    bus.io_ex_valid     = v;
    bus.io_ex_funct3    = f3;
    bus.io_ex_pc        = pc;
    bus.io_ex_target    = tgt;
    bus.io_ex_predTaken = pred;
    bus.io_stall        = stall;
    bus.io_BrEq         = eq;
    bus.io_BrLt         = lt;
  endtask

  task automatic idle();
    drive(0, 3'd0, 32'd0, 32'd0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.io_if_pc = 32'd0;
    idle();
    tick();
    checking = 1'b1;
    tick();
    reset = 1'b0;

    // Reset state
    bus.io_if_pc = 32'h0;
    #1;
    chk("rst_pred", 32'(bus.io_if_predTaken), 32'd0);
    chk("rst_branches", bus.io_branches, 32'd0);
    chk("rst_mispredicts", bus.io_mispredicts, 32'd0);
    chk("rst_redirect", 32'(bus.io_redirect), 32'd0);
    chk("rst_flush", 32'(bus.io_flush), 32'd0);
    chk("rst_redirect_pc", bus.io_redirect_pc, 32'd0);

    // Taken BEQ predicted not-taken
    drive(1, 3'b000, 32'h100, 32'h140, 0, 0, 1, 0);
    tick();
    idle();
    chk("beq_redirect", 32'(bus.io_redirect), 32'd1);
    chk("beq_flush", 32'(bus.io_flush), 32'd1);
    chk("beq_rpc", bus.io_redirect_pc, 32'h140);
    chk("beq_mis", bus.io_mispredicts, 32'd1);
    chk("beq_br", bus.io_branches, 32'd1);
    tick();
    chk("beq_pulse_end", 32'(bus.io_redirect), 32'd0);
    bus.io_if_pc = 32'h100;
    #1;
    chk("beq_bht_pred", 32'(bus.io_if_predTaken), 32'd1);

    // Not-taken BGEU predicted taken at top of address space
    drive(1, 3'b111, 32'hFFFF_FFFC, 32'h1234, 1, 0, 0, 1);
    #1;
    chk("bgeu_brun", 32'(bus.io_BrUn), 32'd1);
    tick();
    idle();
    chk("bgeu_redirect", 32'(bus.io_redirect), 32'd1);
    chk("bgeu_rpc_wrap", bus.io_redirect_pc, 32'h0);
    tick();

    // Branch in the shadow cycle is squashed
    drive(1, 3'b000, 32'h200, 32'h280, 1, 0, 0, 0);
    tick();
    chk("shadow_first_redirect", 32'(bus.io_redirect), 32'd1);
    drive(1, 3'b001, 32'h400, 32'h480, 0, 0, 0, 0);
    tick();
    chk("shadow_br", bus.io_branches, 32'd3);
    chk("shadow_mis", bus.io_mispredicts, 32'd3);
    chk("shadow_no_redirect", 32'(bus.io_redirect), 32'd0);
    idle();
    tick();
    chk("shadow_idle_redirect", 32'(bus.io_redirect), 32'd0);

    // Saturation at a fresh reset
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    bus.io_if_pc = 32'h304;
    drive(1, 3'b001, 32'h304, 32'h404, 1, 0, 0, 0);
    tick();
    tick();
    tick();
    chk("sat_br", bus.io_branches, 32'd3);
    chk("sat_mis", bus.io_mispredicts, 32'd0);
    chk("sat_redirect", 32'(bus.io_redirect), 32'd0);
    chk("sat_pred", 32'(bus.io_if_predTaken), 32'd1);
    drive(1, 3'b001, 32'h304, 32'h404, 1, 0, 1, 0);
    tick();
    idle();
    #1;
    chk("sat_dec_pred", 32'(bus.io_if_predTaken), 32'd1);
    tick();

    // Illegal funct3 then stalled mispredict
    drive(1, 3'b010, 32'h500, 32'h600, 1, 0, 1, 1);
    tick();
    chk("illegal_br", bus.io_branches, 32'd4);
    chk("illegal_redirect", 32'(bus.io_redirect), 32'd0);
    drive(1, 3'b000, 32'h600, 32'h700, 0, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_redirect", 32'(bus.io_redirect), 32'd0);
      chk("stall_br", bus.io_branches, 32'd4);
    end
    bus.io_stall = 1'b0;
    tick();
    chk("unstall_redirect", 32'(bus.io_redirect), 32'd1);
    chk("unstall_rpc", bus.io_redirect_pc, 32'h700);
    chk("unstall_br", bus.io_branches, 32'd5);
    chk("unstall_mis", bus.io_mispredicts, 32'd2);
    idle();
    tick();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive(($urandom_range(0, 3) != 0),
            3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 31)) << 2,
            $urandom,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      bus.io_if_pc = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 15)) << 2;
      tick();
    end
    reset = 1'b0;
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Execute-stage branch resolution unit for the RV151 pipeline, on the opposite side of the branch comparator interface. It drives `io_BrUn` to the comparator from the branch's funct3, consumes `io_BrEq`/`io_BrLt`, and decides taken/not-taken. It checks that decision against the fetch-time prediction and issues a registered one-cycle redirect plus flush on mispredict. It also owns the 2-bit branch history table (BHT) that supplies fetch predictions, and keeps branch/mispredict counters.

## Interface
Parameters:
- `BHT_IDX_BITS`, default 4: BHT has 2^BHT_IDX_BITS entries, indexed by pc[BHT_IDX_BITS+1:2].

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `io_ex_valid` in 1: a conditional branch occupies EX this cycle.
- `io_ex_funct3` in 3: branch funct3.
- `io_ex_pc` in 32: PC of the EX branch.
- `io_ex_target` in 32: taken target, pc + B-immediate, computed upstream.
- `io_ex_predTaken` in 1: prediction carried down from fetch.
- `io_stall` in 1: pipeline hold; EX contents are not retiring.
- `io_BrEq` in 1: from comparator.
- `io_BrLt` in 1: from comparator.
- `io_BrUn` out 1: to comparator; combinational, equals funct3[1].
- `io_if_pc` in 32: fetch PC for lookup.
- `io_if_predTaken` out 1: combinational BHT prediction for io_if_pc.
- `io_redirect` out 1: registered mispredict pulse.
- `io_redirect_pc` out 32: registered corrected PC, valid while io_redirect is high.
- `io_flush` out 1: registered; squash IF/ID; identical to io_redirect.
- `io_branches` out 32: resolved-branch count.
- `io_mispredicts` out 32: mispredict count.

## Operation
- Taken decision by funct3:
  - 000 BEQ: BrEq. 001 BNE: !BrEq.
  - 100 BLT and 110 BLTU: BrLt. 101 BGE and 111 BGEU: !BrLt.
  - 010 and 011 are illegal: not taken, no BHT update, no count, no redirect.
- A resolving event requires io_ex_valid, !io_stall, legal funct3, and state IDLE.
- On a resolving event:
  - io_branches increments.
  - BHT[idx(io_ex_pc)] updates: taken saturates up at 11, not-taken saturates down at 00.
- Mispredict is taken != io_ex_predTaken. On mispredict:
  - io_mispredicts increments.
  - Next cycle, io_redirect=io_flush=1 and io_redirect_pc = taken ? io_ex_target : io_ex_pc+4. The add is a 32-bit wrap.
- Prediction: io_if_predTaken = BHT[idx(io_if_pc)][1].
- FSM:
  - IDLE goes to SHADOW on mispredict; otherwise stays in IDLE.
  - SHADOW goes to IDLE unconditionally after 1 cycle. Outputs io_redirect/io_flush are high only in SHADOW.
  - In SHADOW the EX instruction is wrong-path: io_ex_valid is ignored, with no update, no count and no redirect, even if io_stall=0.
- Counters wrap 0xFFFFFFFF→0.
- Reset:
  - State IDLE.
  - io_redirect=0, io_flush=0, io_redirect_pc=0.
  - Both counters 0.
  - All BHT entries 01 (weakly not-taken).
- Reset asserted in SHADOW forces IDLE the next cycle; a pending redirect is dropped.

## Timing
- io_BrUn and io_if_predTaken have zero latency (combinational). The comparator result is consumed in the same cycle.
- Redirect latency is 1 cycle from the resolving edge, and the pulse lasts exactly 1 cycle.
- BHT write-then-read: a lookup of the index being written in the same cycle returns the old value; the new value is visible next cycle.
- Counter values are visible the cycle after the event.
- io_stall=1 in IDLE: no state change. The same branch resolves when the stall drops; the comparator inputs are re-sampled then.

## Structure
- Package `branch_pkg` holds:
  - funct3 constants (BEQ…BGEU);
  - 2-bit counter encodings (SNT=00, WNT=01, WT=10, ST=11);
  - FSM state encoding (IDLE, SHADOW).
- Sub-module `branch_bht`:
  - BHT array and saturating update;
  - one combinational read port and one synchronous write port;
  - reset initialisation.
- Top level holds the funct3 decode, FSM, redirect registers and counters.

## Test plan
- Reset, then lookup io_if_pc=0x0 → io_if_predTaken=0, counters=0, io_redirect=0.
- BEQ at pc 0x100, BrEq=1, predTaken=0 → next cycle io_redirect=1 and io_redirect_pc=ex_target (0x140), for one cycle only. io_mispredicts=1. BHT[0] becomes 10, so a lookup of 0x100 predicts 1.
- BGEU, BrLt=1, predTaken=1, pc 0xFFFFFFFC → io_BrUn=1 and io_redirect_pc=0x00000000 (wrap).
- Mispredict followed by a valid branch in the SHADOW cycle → that branch is ignored: io_branches is unchanged and no second redirect fires.
- Three taken BNEs at the same pc with correct predictions → counter saturates at 11, no redirects, io_branches=3. A following not-taken branch brings the counter to 10, and the prediction stays 1.
- funct3=010 with valid → no counts and no redirect. io_stall=1 with a mispredicting branch → no redirect until the stall drops.
